// File: rtl/pi_dpi_capture.sv
// Raspberry Pi DPI capture in the x6 pixel-clock domain: phase-aligned sampling,
// position tracking and line-length lock. Optional colour bars via DPI_TESTPATTERN_EN.
`timescale 1ns/1ps
module pi_dpi_capture #(
  parameter int DATA_W       = 18,
  parameter int SAMPLE_PHASE = 3,
  parameter int H_TOTAL      = 864,
  parameter int LOCK_LINES   = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 10
) (
  input  logic              pixelClockX6,
  input  logic              nReset,
  input  logic [2:0]        pixelClockPhase,
  input  logic [DATA_W-1:0] dpiData,
  input  logic              dpiHsync,
  input  logic              dpiVsync,
`ifdef DPI_TESTPATTERN_EN
  input  logic              testPatternSel,
`endif
  output logic [DATA_W-1:0] pixelData,
  output logic              pixelValid,
  output logic [X_W-1:0]    pixelX,
  output logic [Y_W-1:0]    lineY,
  output logic              lineStart,
  output logic              frameStart,
  output logic              syncLocked,
  output logic              lineLengthError
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              hs;
    logic              vs;
  } dpiSample_t;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} lockState_t;

  localparam logic [2:0]     SAMPLE_PH   = 3'(SAMPLE_PHASE);
  localparam logic [11:0]    LEN_TARGET  = 12'(H_TOTAL);
  localparam logic [11:0]    LEN_MAX     = '1;
  localparam logic [3:0]     GOOD_TARGET = 4'(LOCK_LINES);
  localparam logic [X_W-1:0] X_MAX       = '1;

  dpiSample_t  s1;
  logic        s1Valid;
  logic        prevHs, prevVs, vsPending;
  logic [11:0] lenCnt;
  logic [3:0]  goodCnt;
  lockState_t  state;

  logic              hsEdge, vsEdge, lenMatch, lostLock, nxtLocked;
  lockState_t        nxtState;
  logic [3:0]        nxtGood;
  logic [11:0]       nxtLen;
  logic [X_W-1:0]    nxtX;
  logic [Y_W-1:0]    nxtY;
  logic [DATA_W-1:0] capData;

`ifdef DPI_TESTPATTERN_EN
  localparam int CW = DATA_W / 3;
  logic [2:0] bar;
  // Bar index from the top three bits of the new X; each component fully on or off.
  always_comb begin
    bar     = nxtX[X_W-1 -: 3];
    capData = testPatternSel ? {{CW{~bar[2]}}, {CW{~bar[1]}}, {CW{~bar[0]}}} : s1.data;
  end
`else
  always_comb capData = s1.data;
`endif

  always_comb begin
    hsEdge    = s1.hs & ~prevHs;
    vsEdge    = s1.vs & ~prevVs;
    lenMatch  = (lenCnt == LEN_TARGET);
    nxtState  = state;
    nxtGood   = goodCnt;
    lostLock  = 1'b0;
    if (hsEdge) begin
      unique case (state)
        SEARCH: begin
          nxtState = VERIFY;
          nxtGood  = '0;
        end
        VERIFY: begin
          if (lenMatch) begin
            nxtGood = goodCnt + 4'd1;
            if (nxtGood == GOOD_TARGET) nxtState = LOCKED;
          end else begin
            nxtGood = '0;
          end
        end
        LOCKED: begin
          if (!lenMatch) begin
            nxtState = SEARCH;
            lostLock = 1'b1;
          end
        end
        default: nxtState = SEARCH;
      endcase
    end else if (lenCnt == LEN_MAX && state != SEARCH) begin
      // Sync has vanished: give up rather than wait forever for the next hsync.
      nxtState = SEARCH;
      nxtGood  = '0;
      lostLock = (state == LOCKED);
    end
    nxtLocked = (nxtState == LOCKED);

    if (hsEdge) begin
      nxtX   = '0;
      nxtY   = (vsEdge || vsPending) ? '0 : lineY + 1'b1;
      nxtLen = 12'd1;
    end else begin
      nxtX   = (pixelX == X_MAX) ? pixelX : pixelX + 1'b1;
      nxtY   = lineY;
      nxtLen = (lenCnt == LEN_MAX) ? lenCnt : lenCnt + 12'd1;
    end
  end

  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      s1              <= '0;
      s1Valid         <= 1'b0;
      prevHs          <= 1'b0;
      prevVs          <= 1'b0;
      vsPending       <= 1'b0;
      lenCnt          <= '0;
      goodCnt         <= '0;
      state           <= SEARCH;
      pixelData       <= '0;
      pixelValid      <= 1'b0;
      pixelX          <= '0;
      lineY           <= '0;
      lineStart       <= 1'b0;
      frameStart      <= 1'b0;
      syncLocked      <= 1'b0;
      lineLengthError <= 1'b0;
    end else begin
      // Phases 6/7 never match a legal SAMPLE_PHASE, so they never sample.
      s1Valid <= (pixelClockPhase == SAMPLE_PH);
      if (pixelClockPhase == SAMPLE_PH) s1 <= '{data: dpiData, hs: dpiHsync, vs: dpiVsync};

      pixelValid      <= 1'b0;
      lineStart       <= 1'b0;
      frameStart      <= 1'b0;
      lineLengthError <= 1'b0;

      if (s1Valid) begin
        prevHs          <= s1.hs;
        prevVs          <= s1.vs;
        vsPending       <= hsEdge ? 1'b0 : (vsPending | vsEdge);
        lenCnt          <= nxtLen;
        goodCnt         <= nxtGood;
        state           <= nxtState;
        pixelX          <= nxtX;
        lineY           <= nxtY;
        pixelData       <= capData;
        syncLocked      <= nxtLocked;
        pixelValid      <= nxtLocked;
        lineStart       <= nxtLocked & hsEdge;
        frameStart      <= nxtLocked & hsEdge & (nxtY == '0);
        lineLengthError <= lostLock;
      end
    end
  end

endmodule

// File: tb/tb_pi_dpi_capture.sv
// Scoreboard bench for pi_dpi_capture: line generator pushes expected pixels, negedge monitor pops.
`timescale 1ns/1ps
module tb_pi_dpi_capture;
  localparam int DW = 18;
  localparam int XW = 10;
  localparam int YW = 10;

  logic          pixelClockX6 = 1'b0;
  logic          nReset = 1'b1;
  logic [2:0]    pixelClockPhase = 3'd0;
  logic [DW-1:0] dpiData = '0;
  logic          dpiHsync = 1'b0;
  logic          dpiVsync = 1'b0;
`ifdef DPI_TESTPATTERN_EN
  logic          testPatternSel = 1'b0;
`endif
  logic [DW-1:0] pixelData;
  logic          pixelValid;
  logic [XW-1:0] pixelX;
  logic [YW-1:0] lineY;
  logic          lineStart, frameStart, syncLocked, lineLengthError;

  pi_dpi_capture dut (
    .pixelClockX6(pixelClockX6), .nReset(nReset), .pixelClockPhase(pixelClockPhase),
    .dpiData(dpiData), .dpiHsync(dpiHsync), .dpiVsync(dpiVsync),
`ifdef DPI_TESTPATTERN_EN
    .testPatternSel(testPatternSel),
`endif
    .pixelData(pixelData), .pixelValid(pixelValid), .pixelX(pixelX), .lineY(lineY),
    .lineStart(lineStart), .frameStart(frameStart), .syncLocked(syncLocked),
    .lineLengthError(lineLengthError)
  );

  always #6 pixelClockX6 = ~pixelClockX6;

  typedef struct {
    logic [DW-1:0] d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          ls;
    logic          fs;
    int            ph;
  } exp_t;

  exp_t          q[$];
  exp_t          mexp;
  int            nChk = 0;
  int            nPass = 0;
  int            errPulses = 0;
  logic [YW-1:0] ey = '0;
  bit            vsPend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every presented pixel must match the oldest expected one.
  always @(negedge pixelClockX6) begin
    if (lineLengthError) errPulses++;
    if (pixelValid) begin
      if (q.size() == 0) begin
        nChk++;
        $display("FAIL unexpected_pixel: pixelValid=1 x=%0d y=%0d, expected no pixel", pixelX, lineY);
      end else begin
        mexp = q.pop_front();
        chk("pixel", {pixelData, pixelX, lineY, lineStart, frameStart},
            {mexp.d, mexp.x, mexp.y, mexp.ls, mexp.fs});
        if (mexp.ph >= 0) chk("valid_phase", 64'(pixelClockPhase), 64'(mexp.ph));
      end
    end
  end

  task automatic pixel(input logic [DW-1:0] d, input logic hs, input logic vs, input bit full);
    if (full) begin
      for (int p = 0; p < 6; p++) begin
        @(posedge pixelClockX6); #1;
        pixelClockPhase = 3'(p);
        if (p == 3) begin
          dpiData = d; dpiHsync = hs; dpiVsync = vs;
        end else begin
          dpiData = DW'($urandom); dpiHsync = 1'($urandom); dpiVsync = 1'($urandom);
        end
      end
    end else begin
      @(posedge pixelClockX6); #1;
      pixelClockPhase = 3'd3; dpiData = d; dpiHsync = hs; dpiVsync = vs;
      @(posedge pixelClockX6); #1;
      pixelClockPhase = 3'(6 + $urandom_range(0, 1));
      dpiData = DW'($urandom); dpiHsync = 1'($urandom); dpiVsync = 1'($urandom);
    end
  endtask

  // One line: hsync on the first pixels, optional vsync with it or a lone vsync on the last pixel.
  task automatic line(input int n, input bit vs, input bit lk, input bit full, input bit vsMid);
    int            hw;
    logic [DW-1:0] d;
    exp_t          e;
    hw = (n / 2 < 64) ? n / 2 : 64;
    ey = (vs || vsPend) ? '0 : ey + 1'b1;
    vsPend = vsMid;
    for (int i = 0; i < n; i++) begin
      d = full ? 18'h15A5A : {ey[7:0], i[9:0]};
      if (lk && i < 4095) begin
        e.d = d; e.x = (i < 1023) ? XW'(i) : XW'(1023); e.y = ey;
        e.ls = (i == 0); e.fs = (i == 0) && (ey == 0); e.ph = full ? 5 : -1;
        q.push_back(e);
      end
      pixel(d, i < hw, (vs && i < hw) || (vsMid && i == n - 1), full);
    end
    @(posedge pixelClockX6); @(negedge pixelClockX6);
    chk("syncLocked_eol", 64'(syncLocked), 64'(lk && n < 4096));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 nReset = 1'b0;
    repeat (3) @(posedge pixelClockX6);
    #1;
    chk("rst_pixelValid", 64'(pixelValid), 64'd0);
    chk("rst_pixelData", 64'(pixelData), 64'd0);
    chk("rst_pixelX", 64'(pixelX), 64'd0);
    chk("rst_lineY", 64'(lineY), 64'd0);
    chk("rst_syncLocked", 64'(syncLocked), 64'd0);
    chk("rst_lineLengthError", 64'(lineLengthError), 64'd0);
    chk("rst_strobes", 64'({lineStart, frameStart}), 64'd0);
    nReset = 1'b1;
    repeat (3) @(posedge pixelClockX6);
    #1 chk("idle_no_sample", 64'({pixelValid, pixelX, lineY, syncLocked}), 64'd0);

    // Lock acquisition: lock at the fifth hsync edge.
    line(864, 1, 0, 0, 0);
    repeat (3) line(864, 0, 0, 0, 0);
    line(864, 0, 1, 0, 0);
    line(864, 0, 1, 1, 0);          // all phases exercised, constant 0x15A5A
    line(864, 1, 1, 0, 0);          // vsync with hsync: lineY=0, frameStart
    line(863, 0, 1, 0, 0);          // short line
    chk("pixelData_hold", 64'(pixelData), 64'({ey[7:0], 10'd862}));
    line(864, 0, 0, 0, 0);          // mismatch detected here
    chk("err_on_short_line", 64'(errPulses), 64'd1);

    // Relock after loss, then hsync stops: timeout from LOCKED.
    repeat (4) line(864, 0, 0, 0, 0);
    line(864, 0, 1, 0, 0);
    line(4100, 0, 1, 0, 0);
    chk("err_on_timeout", 64'(errPulses), 64'd2);

    // Relock, then reset mid-line.
    repeat (4) line(864, 0, 0, 0, 0);
    line(864, 0, 1, 0, 0);
    line(100, 0, 1, 0, 0);
    @(posedge pixelClockX6); #2 nReset = 1'b0;
    #1 chk("rst_mid_line", 64'({pixelData, pixelValid, pixelX, lineY, lineStart, frameStart,
                                syncLocked, lineLengthError}), 64'd0);
    repeat (3) @(posedge pixelClockX6);
    #1 nReset = 1'b1;
    line(864, 1, 0, 0, 0);
    repeat (3) line(864, 0, 0, 0, 0);
    line(864, 0, 1, 0, 0);
    line(100, 0, 1, 0, 0);

    // Frame wrap with short unlocked lines; lineY tracks regardless of lock.
    line(4, 1, 0, 0, 0);
    chk("err_on_frame_entry", 64'(errPulses), 64'd3);
    repeat (624) line(4, 0, 0, 0, 0);
    chk("lineY_624", 64'(lineY), 64'd624);
    line(4, 1, 0, 0, 0);
    chk("lineY_wrap_vsync", 64'(lineY), 64'd0);
    line(4, 0, 0, 0, 1);
    chk("lineY_lone_vsync_deferred", 64'(lineY), 64'd1);
    line(4, 0, 0, 0, 0);
    chk("lineY_lone_vsync_applied", 64'(lineY), 64'd0);
    chk("pixelX_unlocked", 64'(pixelX), 64'd3);
    chk("pixelData_unlocked", 64'(pixelData), 64'd3);

`ifdef DPI_TESTPATTERN_EN
    testPatternSel = 1'b1;
    for (int i = 0; i < 900; i++) begin
      pixel(18'h2AAAA, i < 64, 1'b0, 1'b0);
      if (i == 0 || i == 896) begin
        @(posedge pixelClockX6); @(negedge pixelClockX6);
        chk(i == 0 ? "tp_bar0" : "tp_bar7", 64'(pixelData), (i == 0) ? 64'h3FFFF : 64'h0);
      end
    end
    testPatternSel = 1'b0;
`endif

    repeat (4) @(posedge pixelClockX6);
    @(negedge pixelClockX6);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    chk("err_total", 64'(errPulses), 64'd3);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
